lcd_frame_writer: RTL and testbench

LCD_FRAME_WRITER -- requirements
Module: lcd_frame_writer

---
 rtl/ppu_pkg.sv | 14 +
 rtl/lcd_frame_writer_px_pack4.sv | 29 ++
 rtl/lcd_frame_writer.sv | 186 ++++++++++++++++++
 tb/tb_lcd_frame_writer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared PPU constants and the frame writer state encoding.
package ppu_pkg;

  localparam int H_PIX_DEF      = 160;
  localparam int V_LINES_DEF    = 144;
  localparam int BYTES_PER_LINE = H_PIX_DEF / 4;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    ACTIVE     = 2'd1,
    VBLANK     = 2'd2
  } wr_state_e;

endpackage

// File: rtl/lcd_frame_writer_px_pack4.sv
// Packs four 2-bit shades into one byte, first pixel in the low bits.
module px_pack4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       shift_i,
  input  logic [1:0] px_i,
  output logic [7:0] byte_o,
  output logic       last_o
);

  logic [7:0] sh_q;
  logic [1:0] ph_q;

  // byte_o is the completed byte when the 4th pixel is being shifted in
  assign byte_o = {px_i, sh_q[7:2]};
  assign last_o = (ph_q == 2'd3);

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      sh_q <= '0;
      ph_q <= '0;
    end else if (shift_i) begin
      sh_q <= byte_o;
      ph_q <= ph_q + 2'd1;
    end
  end

endmodule

// File: rtl/lcd_frame_writer.sv
// Captures the PPU pixel stream into a double-buffered packed framebuffer,
// validating line/frame geometry and swapping banks only on clean frames.
module lcd_frame_writer
  import ppu_pkg::*;
#(
  parameter int H_PIX   = H_PIX_DEF,
  parameter int V_LINES = V_LINES_DEF,
  parameter int ADDR_W  = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lcd_hsync,
  input  logic              lcd_vsync,
  input  logic              lcd_pixel,
  input  logic [1:0]        lcd_color,
  input  logic              rd_busy,
  output logic              fb_we,
  output logic [ADDR_W:0]   fb_addr,
  output logic [7:0]        fb_data,
  output logic              rd_bank,
  output logic              frame_ready,
  output logic              frame_drop,
  output logic              line_err,
  output logic              frame_err
);

  localparam int XW = $clog2(H_PIX + 1);
  localparam int YW = $clog2(V_LINES + 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_PIX / 4);

  wr_state_e         state_q;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic [ADDR_W-1:0] row_base_q;
  logic              line_bad_q, frame_bad_q;
  logic              hs_q, vs_q;
  logic              rd_bank_q;
  logic              fb_we_q;
  logic [ADDR_W:0]   fb_addr_q;
  logic [7:0]        fb_data_q;
  logic              frame_ready_q, frame_drop_q, line_err_q, frame_err_q;

  logic              hs_rise, vs_rise, vs_fall, in_active;
  logic              px_ok, px_drop;
  logic              line_bad_now, frame_bad_now;
  logic [YW-1:0]     y_inc, y_end;
  logic [ADDR_W-1:0] wr_addr;
  logic              pk_clr, pk_last;
  logic [7:0]        pk_byte;

  assign hs_rise   = lcd_hsync & ~hs_q;
  assign vs_rise   = lcd_vsync & ~vs_q;
  assign vs_fall   = ~lcd_vsync & vs_q;
  assign in_active = (state_q == ACTIVE);

  assign px_ok   = in_active & lcd_pixel & ~lcd_hsync & ~lcd_vsync &
                   (x_q < XW'(H_PIX)) & (y_q < YW'(V_LINES));
  assign px_drop = in_active & lcd_pixel & ~px_ok;

  // A pixel dropped on the hsync edge itself still counts against the ending line
  assign line_bad_now  = line_bad_q | px_drop | (x_q != XW'(H_PIX));
  assign frame_bad_now = frame_bad_q | (hs_rise & line_bad_now);

  assign y_inc   = (y_q < YW'(V_LINES)) ? y_q + YW'(1) : y_q;
  assign y_end   = hs_rise ? y_inc : y_q;
  assign wr_addr = row_base_q + ADDR_W'(x_q >> 2);

  assign pk_clr = ~in_active | hs_rise | vs_rise | vs_fall;

  px_pack4 u_pack (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (pk_clr),
    .shift_i (px_ok),
    .px_i    (lcd_color),
    .byte_o  (pk_byte),
    .last_o  (pk_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= WAIT_FRAME;
      x_q           <= '0;
      y_q           <= '0;
      row_base_q    <= '0;
      line_bad_q    <= 1'b0;
      frame_bad_q   <= 1'b0;
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      rd_bank_q     <= 1'b1;
      fb_we_q       <= 1'b0;
      fb_addr_q     <= '0;
      fb_data_q     <= '0;
      frame_ready_q <= 1'b0;
      frame_drop_q  <= 1'b0;
      line_err_q    <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      hs_q          <= lcd_hsync;
      vs_q          <= lcd_vsync;
      fb_we_q       <= 1'b0;
      frame_ready_q <= 1'b0;
      frame_drop_q  <= 1'b0;
      line_err_q    <= 1'b0;
      frame_err_q   <= 1'b0;

      case (state_q)
        WAIT_FRAME: begin
          if (vs_fall) begin
            state_q     <= ACTIVE;
            x_q         <= '0;
            y_q         <= '0;
            row_base_q  <= '0;
            line_bad_q  <= 1'b0;
            frame_bad_q <= 1'b0;
          end
        end

        ACTIVE: begin
          if (px_ok) begin
            x_q <= x_q + XW'(1);
            if (pk_last) begin
              fb_we_q   <= 1'b1;
              fb_addr_q <= {~rd_bank_q, wr_addr};
              fb_data_q <= pk_byte;
            end
          end else if (px_drop) begin
            line_bad_q <= 1'b1;
          end

          if (hs_rise) begin
            line_err_q <= line_bad_now;
            if (line_bad_now) frame_bad_q <= 1'b1;
            x_q        <= '0;
            line_bad_q <= 1'b0;
            y_q        <= y_inc;
            if (y_q < YW'(V_LINES)) row_base_q <= row_base_q + ROW_STEP;
          end

          // Frame end: commit, drop or reject; overrides the line-end updates above
          if (vs_rise) begin
            state_q <= VBLANK;
            if ((y_end != YW'(V_LINES)) || frame_bad_now) begin
              frame_err_q <= 1'b1;
            end else if (!rd_busy) begin
              rd_bank_q     <= ~rd_bank_q;
              frame_ready_q <= 1'b1;
            end else begin
              frame_drop_q <= 1'b1;
            end
          end else if (vs_fall) begin
            frame_err_q <= 1'b1;
            x_q         <= '0;
            y_q         <= '0;
            row_base_q  <= '0;
            line_bad_q  <= 1'b0;
            frame_bad_q <= 1'b0;
          end
        end

        VBLANK: begin
          if (vs_fall) begin
            state_q     <= ACTIVE;
            x_q         <= '0;
            y_q         <= '0;
            row_base_q  <= '0;
            line_bad_q  <= 1'b0;
            frame_bad_q <= 1'b0;
          end
        end

        default: state_q <= WAIT_FRAME;
      endcase
    end
  end

  assign fb_we       = fb_we_q;
  assign fb_addr     = fb_addr_q;
  assign fb_data     = fb_data_q;
  assign rd_bank     = rd_bank_q;
  assign frame_ready = frame_ready_q;
  assign frame_drop  = frame_drop_q;
  assign line_err    = line_err_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Directed bench for lcd_frame_writer: full frames, malformed lines, drops and resets.
module tb_lcd_frame_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        lcd_hsync, lcd_vsync, lcd_pixel;
  logic [1:0]  lcd_color;
  logic        rd_busy;
  logic        fb_we;
  logic [13:0] fb_addr;
  logic [7:0]  fb_data;
  logic        rd_bank, frame_ready, frame_drop, line_err, frame_err;

  lcd_frame_writer dut (
    .clk         (clk),
    .rst         (rst),
    .lcd_hsync   (lcd_hsync),
    .lcd_vsync   (lcd_vsync),
    .lcd_pixel   (lcd_pixel),
    .lcd_color   (lcd_color),
    .rd_busy     (rd_busy),
    .fb_we       (fb_we),
    .fb_addr     (fb_addr),
    .fb_data     (fb_data),
    .rd_bank     (rd_bank),
    .frame_ready (frame_ready),
    .frame_drop  (frame_drop),
    .line_err    (line_err),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  int wr_cnt, addr_bad, data_bad, unexp_wr, lerr_cnt, ferr_cnt, rdy_cnt, drop_cnt;
  logic [13:0] exp_q[$];
  logic [13:0] last_addr;
  logic        exp_bank;
  logic        capture_on;
  int          cur_y;

  // Write/pulse monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (fb_we) begin
      wr_cnt++;
      last_addr = fb_addr;
      if (fb_data !== 8'hE4) data_bad++;
      if (exp_q.size() == 0) unexp_wr++;
      else begin
        if (fb_addr !== exp_q[0]) addr_bad++;
        exp_q.delete(0);
      end
    end
    if (line_err)    lerr_cnt++;
    if (frame_err)   ferr_cnt++;
    if (frame_ready) rdy_cnt++;
    if (frame_drop)  drop_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pix, input logic [1:0] c, input logic hs, input logic vs);
    lcd_pixel = pix;
    lcd_color = c;
    lcd_hsync = hs;
    lcd_vsync = vs;
    tick();
  endtask

  task automatic clear_counts();
    wr_cnt = 0; addr_bad = 0; data_bad = 0; unexp_wr = 0;
    lerr_cnt = 0; ferr_cnt = 0; rdy_cnt = 0; drop_cnt = 0;
    last_addr = '0;
    exp_q.delete();
  endtask

  task automatic send_line(input int npix, input bit hs_pix);
    for (int x = 0; x < npix; x++) begin
      if (capture_on && x < 160 && cur_y < 144 && (x % 4) == 3)
        exp_q.push_back({exp_bank, 13'(cur_y * 40 + x / 4)});
      drive(1'b1, 2'(x % 4), 1'b0, 1'b0);
    end
    drive(hs_pix, 2'd0, 1'b1, 1'b0);
    drive(1'b0, 2'd0, 1'b1, 1'b0);
    if (cur_y < 144) cur_y++;
  endtask

  task automatic vsync_pulse();
    repeat (4) drive(1'b0, 2'd0, 1'b0, 1'b1);
    repeat (2) drive(1'b0, 2'd0, 1'b0, 1'b0);
    cur_y = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rd_busy = 1'b0; capture_on = 1'b0; exp_bank = 1'b0; cur_y = 0;
    lcd_pixel = 1'b0; lcd_color = 2'd0; lcd_hsync = 1'b0; lcd_vsync = 1'b1;
    clear_counts();
    repeat (3) tick();
    tests_run++; if (fb_we !== 1'b0) begin tests_failed++; $display("FAIL reset_fb_we got %b exp 0", fb_we); end
    tests_run++; if (fb_addr !== 14'd0) begin tests_failed++; $display("FAIL reset_fb_addr got %0d exp 0", fb_addr); end
    tests_run++; if (fb_data !== 8'd0) begin tests_failed++; $display("FAIL reset_fb_data got %h exp 00", fb_data); end
    tests_run++; if (rd_bank !== 1'b1) begin tests_failed++; $display("FAIL reset_rd_bank got %b exp 1", rd_bank); end
    tests_run++;
    if ({frame_ready, frame_drop, line_err, frame_err} !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_pulses got %b exp 0000", {frame_ready, frame_drop, line_err, frame_err});
    end
    // Release with vsync high: the apparent rising edge must be ignored
    rst = 1'b0;
    repeat (4) drive(1'b1, 2'd3, 1'b0, 1'b1);
    tests_run++;
    if (wr_cnt + ferr_cnt + rdy_cnt + drop_cnt + lerr_cnt !== 0) begin
      tests_failed++; $display("FAIL spurious_vsync_activity got %0d exp 0", wr_cnt + ferr_cnt + rdy_cnt + drop_cnt + lerr_cnt);
    end
    repeat (2) drive(1'b0, 2'd0, 1'b0, 1'b0);
    cur_y = 0;
  endtask

  task automatic test_reset_mid();
    clear_counts();
    capture_on = 1'b1; exp_bank = 1'b0;
    for (int l = 0; l < 70; l++) send_line(160, 1'b0);
    tests_run++; if (wr_cnt !== 70 * 40) begin tests_failed++; $display("FAIL pre_reset_writes got %0d exp %0d", wr_cnt, 70 * 40); end
    rst = 1'b1;
    repeat (2) drive(1'b0, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    capture_on = 1'b0;
    clear_counts();
    tests_run++; if (rd_bank !== 1'b1) begin tests_failed++; $display("FAIL midreset_rd_bank got %b exp 1", rd_bank); end
    for (int l = 0; l < 3; l++) send_line(160, 1'b0);
    tests_run++; if (wr_cnt !== 0) begin tests_failed++; $display("FAIL wait_frame_writes got %0d exp 0", wr_cnt); end
    tests_run++; if (lerr_cnt !== 0) begin tests_failed++; $display("FAIL wait_frame_line_err got %0d exp 0", lerr_cnt); end
    vsync_pulse();
    tests_run++;
    if (ferr_cnt + rdy_cnt + drop_cnt !== 0) begin
      tests_failed++; $display("FAIL wait_frame_vsync_pulses got %0d exp 0", ferr_cnt + rdy_cnt + drop_cnt);
    end
  endtask

  task automatic test_full_frame();
    clear_counts();
    capture_on = 1'b1; exp_bank = 1'b0;
    for (int l = 0; l < 144; l++) send_line(160, 1'b0);
    vsync_pulse();
    tests_run++; if (wr_cnt !== 5760) begin tests_failed++; $display("FAIL full_wr_cnt got %0d exp 5760", wr_cnt); end
    tests_run++; if (data_bad !== 0) begin tests_failed++; $display("FAIL full_fb_data bad bytes got %0d exp 0", data_bad); end
    tests_run++; if (addr_bad + unexp_wr !== 0) begin tests_failed++; $display("FAIL full_fb_addr bad got %0d exp 0", addr_bad + unexp_wr); end
    tests_run++; if (exp_q.size() !== 0) begin tests_failed++; $display("FAIL full_missing_writes got %0d exp 0", exp_q.size()); end
    tests_run++; if (last_addr !== {1'b0, 13'd5759}) begin tests_failed++; $display("FAIL full_last_addr got %h exp %h", last_addr, {1'b0, 13'd5759}); end
    tests_run++; if (rdy_cnt !== 1) begin tests_failed++; $display("FAIL full_frame_ready got %0d exp 1", rdy_cnt); end
    tests_run++; if (lerr_cnt + ferr_cnt + drop_cnt !== 0) begin tests_failed++; $display("FAIL full_err_pulses got %0d exp 0", lerr_cnt + ferr_cnt + drop_cnt); end
    tests_run++; if (rd_bank !== 1'b0) begin tests_failed++; $display("FAIL full_rd_bank got %b exp 0", rd_bank); end
    exp_bank = 1'b1;
  endtask

  task automatic test_short_line();
    clear_counts();
    for (int l = 0; l < 12; l++) begin
      send_line((l == 10) ? 156 : 160, 1'b0);
      if (l == 9) begin
        tests_run++; if (lerr_cnt !== 0) begin tests_failed++; $display("FAIL short_line_err_early got %0d exp 0", lerr_cnt); end
      end
      if (l == 10) begin
        tests_run++; if (lerr_cnt !== 1) begin tests_failed++; $display("FAIL short_line_err got %0d exp 1", lerr_cnt); end
      end
    end
    vsync_pulse();
    tests_run++; if (wr_cnt !== 12 * 40 - 1) begin tests_failed++; $display("FAIL short_wr_cnt got %0d exp %0d", wr_cnt, 12 * 40 - 1); end
    tests_run++; if (addr_bad + unexp_wr !== 0) begin tests_failed++; $display("FAIL short_fb_addr bad got %0d exp 0", addr_bad + unexp_wr); end
    tests_run++; if (ferr_cnt !== 1) begin tests_failed++; $display("FAIL short_frame_err got %0d exp 1", ferr_cnt); end
    tests_run++; if (rdy_cnt + drop_cnt !== 0) begin tests_failed++; $display("FAIL short_commit got %0d exp 0", rdy_cnt + drop_cnt); end
    tests_run++; if (rd_bank !== 1'b0) begin tests_failed++; $display("FAIL short_rd_bank got %b exp 0", rd_bank); end
  endtask

  task automatic test_bad_pixels();
    clear_counts();
    for (int l = 0; l < 8; l++) send_line((l == 4) ? 161 : 160, l == 2);
    vsync_pulse();
    tests_run++; if (wr_cnt !== 8 * 40) begin tests_failed++; $display("FAIL badpix_wr_cnt got %0d exp %0d", wr_cnt, 8 * 40); end
    tests_run++; if (addr_bad + unexp_wr + data_bad !== 0) begin tests_failed++; $display("FAIL badpix_writes bad got %0d exp 0", addr_bad + unexp_wr + data_bad); end
    tests_run++; if (lerr_cnt !== 2) begin tests_failed++; $display("FAIL badpix_line_err got %0d exp 2", lerr_cnt); end
    tests_run++; if (ferr_cnt !== 1) begin tests_failed++; $display("FAIL badpix_frame_err got %0d exp 1", ferr_cnt); end
    tests_run++; if (rdy_cnt !== 0) begin tests_failed++; $display("FAIL badpix_frame_ready got %0d exp 0", rdy_cnt); end
  endtask

  task automatic test_drop();
    clear_counts();
    rd_busy = 1'b1;
    for (int l = 0; l < 144; l++) send_line(160, 1'b0);
    vsync_pulse();
    rd_busy = 1'b0;
    tests_run++; if (drop_cnt !== 1) begin tests_failed++; $display("FAIL drop_frame_drop got %0d exp 1", drop_cnt); end
    tests_run++; if (rdy_cnt + ferr_cnt !== 0) begin tests_failed++; $display("FAIL drop_other_pulses got %0d exp 0", rdy_cnt + ferr_cnt); end
    tests_run++; if (rd_bank !== 1'b0) begin tests_failed++; $display("FAIL drop_rd_bank got %b exp 0", rd_bank); end
    tests_run++; if (last_addr !== {1'b1, 13'd5759}) begin tests_failed++; $display("FAIL drop_last_addr got %h exp %h", last_addr, {1'b1, 13'd5759}); end
    tests_run++; if (addr_bad + unexp_wr !== 0) begin tests_failed++; $display("FAIL drop_fb_addr bad got %0d exp 0", addr_bad + unexp_wr); end
  endtask

  task automatic test_back_to_back();
    clear_counts();
    for (int l = 0; l < 144; l++) send_line(160, 1'b0);
    vsync_pulse();
    tests_run++; if (wr_cnt !== 5760) begin tests_failed++; $display("FAIL b2b_wr_cnt got %0d exp 5760", wr_cnt); end
    tests_run++; if (addr_bad + unexp_wr + data_bad !== 0) begin tests_failed++; $display("FAIL b2b_writes bad got %0d exp 0", addr_bad + unexp_wr + data_bad); end
    tests_run++; if (last_addr !== {1'b1, 13'd5759}) begin tests_failed++; $display("FAIL b2b_last_addr got %h exp %h", last_addr, {1'b1, 13'd5759}); end
    tests_run++; if (rdy_cnt !== 1) begin tests_failed++; $display("FAIL b2b_frame_ready got %0d exp 1", rdy_cnt); end
    tests_run++; if (drop_cnt + ferr_cnt !== 0) begin tests_failed++; $display("FAIL b2b_other_pulses got %0d exp 0", drop_cnt + ferr_cnt); end
    tests_run++; if (rd_bank !== 1'b1) begin tests_failed++; $display("FAIL b2b_rd_bank got %b exp 1", rd_bank); end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_full_frame();
    test_short_line();
    test_bad_pixels();
    test_drop();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
